// File: rtl/id_ex_ctrl_if.sv
// ID/EX control-stage bundle: ID-side inputs from the pipeline, EX-side controls back.
interface id_ex_ctrl_if #(
    parameter int unsigned REG_W = 5
);
    logic [6:0]       Opcode;
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic [REG_W-1:0] ex_rd;
    logic             redirect;

    logic             ex_ALUSrc;
    logic             ex_MemtoReg;
    logic             ex_RegWrite;
    logic             ex_MemRead;
    logic             ex_MemWrite;
    logic             ex_Branch;
    logic [2:0]       ex_ALUOp;
    logic [1:0]       ex_JalType;
    logic             ex_valid;
    logic             stall;
    logic             flush_ifid;
    logic             halted;

    // Pipeline side: drives ID state, consumes controls.
    modport master (
        output Opcode, id_valid, id_rs1, id_rs2, ex_rd, redirect,
        input  ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch,
        input  ex_ALUOp, ex_JalType, ex_valid, stall, flush_ifid, halted
    );

    // Control stage side.
    modport slave (
        input  Opcode, id_valid, id_rs1, id_rs2, ex_rd, redirect,
        output ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch,
        output ex_ALUOp, ex_JalType, ex_valid, stall, flush_ifid, halted
    );
endinterface

// File: rtl/id_ex_ctrl.sv
// ID/EX control register: opcode decode, load-use stall, bubble insertion and HALT drain FSM.
module id_ex_ctrl #(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter bit          AUIPC_EN     = 1'b1
) (
    input logic         clk,
    input logic         reset_n,
    id_ex_ctrl_if.slave bus
);

    localparam int unsigned CntW = $clog2(DRAIN_CYCLES + 1);
    localparam logic [CntW-1:0] CntInit = CntW'(DRAIN_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);

    typedef enum logic [1:0] {StRun, StDrain, StHalted} state_e;

    typedef struct packed {
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic [2:0] alu_op;
        logic [1:0] jal_type;
    } ctrl_t;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    ctrl_t           ctrl_q, ctrl_d, dec;
    logic            valid_q, valid_d;
    logic            halted_q, halted_d;
    logic            uses_rs1, uses_rs2, is_halt;
    logic            hazard;
    logic            stall_c, flush_c;

    // Opcode decode into the control bundle plus source-register usage.
    always_comb begin
        dec      = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        is_halt  = 1'b0;
        case (bus.Opcode)
            7'b0110011: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 3'b010;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            7'b0010011: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 3'b011;
                uses_rs1      = 1'b1;
            end
            7'b0000011: begin
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_read   = 1'b1;
                dec.alu_op     = 3'b000;
                uses_rs1       = 1'b1;
            end
            7'b0100011: begin
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.alu_op    = 3'b000;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
            end
            7'b1100011: begin
                dec.branch = 1'b1;
                dec.alu_op = 3'b001;
                uses_rs1   = 1'b1;
                uses_rs2   = 1'b1;
            end
            7'b1101111: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 3'b010;
                dec.jal_type  = 2'b10;
            end
            7'b1100111: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 3'b010;
                dec.jal_type  = 2'b01;
                uses_rs1      = 1'b1;
            end
            7'b0110111: begin
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.alu_op    = 3'b100;
            end
            7'b0010111: begin
                // Without AUIPC support this falls through as an unknown opcode (NOP).
                if (AUIPC_EN) begin
                    dec.alu_src   = 1'b1;
                    dec.reg_write = 1'b1;
                    dec.alu_op    = 3'b100;
                end
            end
            7'b1111111: is_halt = 1'b1;
            default: ;
        endcase
    end

    // Load-use hazard against the load currently held in ID/EX.
    always_comb begin
        hazard = valid_q & ctrl_q.mem_read & (bus.ex_rd != '0) & bus.id_valid &
                 ((uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                  (uses_rs2 & (bus.id_rs2 == bus.ex_rd)));
    end

    // Halt FSM next state, drain counter and ID/EX load selection (bubble by default).
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ctrl_d   = '0;
        valid_d  = 1'b0;
        halted_d = halted_q;
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (bus.redirect) begin
                    // Redirect wins over the hazard; a HALT in ID is discarded here.
                    flush_c = 1'b1;
                end else if (hazard) begin
                    stall_c = 1'b1;
                end else if (bus.id_valid) begin
                    if (is_halt) begin
                        state_d = StDrain;
                        cnt_d   = CntInit;
                    end else begin
                        ctrl_d  = dec;
                        valid_d = 1'b1;
                    end
                end
            end
            StDrain: begin
                stall_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d  = StHalted;
                    halted_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntOne;
                end
            end
            StHalted: begin
                stall_c = 1'b1;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    // State and ID/EX control register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StRun;
            cnt_q    <= '0;
            ctrl_q   <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    assign bus.ex_ALUSrc   = ctrl_q.alu_src;
    assign bus.ex_MemtoReg = ctrl_q.mem_to_reg;
    assign bus.ex_RegWrite = ctrl_q.reg_write;
    assign bus.ex_MemRead  = ctrl_q.mem_read;
    assign bus.ex_MemWrite = ctrl_q.mem_write;
    assign bus.ex_Branch   = ctrl_q.branch;
    assign bus.ex_ALUOp    = ctrl_q.alu_op;
    assign bus.ex_JalType  = ctrl_q.jal_type;
    assign bus.ex_valid    = valid_q;
    assign bus.halted      = halted_q;
    // Pipeline-control strobes are forced quiet while reset is held.
    assign bus.stall       = stall_c & reset_n;
    assign bus.flush_ifid  = flush_c & reset_n;

endmodule

// File: doc/id_ex_ctrl.md
# id_ex_ctrl

Registered control stage for the 5-stage RISC-V pipeline: it decodes the 7-bit opcode in ID into the control bundle and latches it into the ID/EX control register. It also owns the pipeline-control decisions around that register: load-use stall detection, bubble insertion on stall or redirect, and a drain-then-stop sequence for HALT. It sits between the IF/ID register and the EX stage, and feeds the datapath muxes, data memory and PC-hold logic.

## Interface
- REG_W, 5: register-index width.
- DRAIN_CYCLES, 3: cycles spent in DRAIN after HALT leaves ID before `halted` asserts. Must be ≥1.
- AUIPC_EN, 1: 1 = decode AUIPC (0010111); 0 = AUIPC treated as an unknown opcode.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- Opcode  in  7  opcode of the instruction in IF/ID.
- id_valid  in  1  IF/ID holds a real instruction.
- id_rs1, id_rs2  in  REG_W  source register indices in ID.
- ex_rd  in  REG_W  destination register index held in the datapath ID/EX register.
- redirect  in  1  taken branch or jump resolved in EX this cycle.
- ex_ALUSrc, ex_MemtoReg, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_Branch  out  1 each  registered controls.
- ex_ALUOp  out  3  registered ALU class.
- ex_JalType  out  2  registered as {JAL, JALR}.
- ex_valid  out  1  ID/EX holds a real instruction (not a bubble).
- stall  out  1  combinational; hold PC and IF/ID.
- flush_ifid  out  1  combinational; clear IF/ID.
- halted  out  1  registered; sticky until reset.

## Operation

**Decode (combinational, registered on load):**
- R 0110011: RegWrite, ALUOp 010.
- I 0010011: ALUSrc, RegWrite, ALUOp 011.
- LW 0000011: ALUSrc, MemtoReg, RegWrite, MemRead, ALUOp 000.
- SW 0100011: ALUSrc, MemWrite, ALUOp 000.
- BR 1100011: Branch, ALUOp 001.
- JAL 1101111: RegWrite, ALUOp 010, JalType 10.
- JALR 1100111: ALUSrc, RegWrite, ALUOp 010, JalType 01.
- LUI 0110111: ALUSrc, RegWrite, ALUOp 100.
- AUIPC 0010111 (only when AUIPC_EN=1): ALUSrc, RegWrite, ALUOp 100.
- HALT 1111111: all controls 0; triggers the halt FSM.
- Any other opcode: all controls 0, ex_valid 1 (behaves as a NOP).

**Source register usage:**
- rs1 is used by R, I, LW, SW, BR, JALR.
- rs2 is used by R, SW, BR.

**Load-use hazard:**
- Condition: `ex_valid & ex_MemRead & ex_rd!=0 & id_valid & ((uses_rs1 & id_rs1==ex_rd) | (uses_rs2 & id_rs2==ex_rd))`.
- Response: stall=1, and a bubble is loaded into ID/EX.
- A bubble means all ex_* controls = 0 and ex_valid = 0.

**Redirect:**
- flush_ifid=1 and a bubble is loaded into ID/EX.
- Redirect has priority over the hazard: stall=0 when redirect=1.
- A HALT sitting in ID during a redirect is discarded and causes no FSM transition.

**Halt FSM (RUN, DRAIN, HALTED):**
- RUN: ID/EX loads the decoded bundle when id_valid and neither stall nor redirect is active; otherwise it loads a bubble.
  - A valid HALT that is loaded moves the FSM to DRAIN and sets cnt=DRAIN_CYCLES-1. ID/EX receives a bubble.
- DRAIN: stall=1, ID/EX loads bubbles, redirect is ignored, flush_ifid=0.
  - If cnt==0, go to HALTED; otherwise cnt decrements.
- HALTED: stall=1, bubbles loaded, halted=1. Only reset exits this state.

**Counter:** width is $clog2(DRAIN_CYCLES+1). It never wraps.

## Timing
- Reset (asynchronous assert, synchronous release):
  - All ex_* outputs = 0 and ex_valid = 0.
  - halted = 0, state = RUN, cnt = 0.
  - stall = 0 and flush_ifid = 0 while in reset.
- Latency: decode to ex_* is one clock. stall and flush_ifid are valid in the same cycle as their inputs.
- Load-use: exactly one bubble per hazard. On the next cycle ex_MemRead=0, so stall deasserts.
- HALT: decoded in ID at cycle T.
  - Edge T+1: state = DRAIN.
  - Edges T+1 through T+DRAIN_CYCLES: counting in DRAIN.
  - halted=1 from edge T+DRAIN_CYCLES+1 onward.
- Reset asserted mid-DRAIN or while HALTED returns all state to reset values immediately.

## Test plan
- Back-to-back R, LW, SW, BR, JAL, JALR, LUI, AUIPC, each with id_valid=1 → one cycle later ex_ALUOp is 010, 000, 000, 001, 010, 010, 100, 100 and the other flags match the decode list; ex_valid=1 throughout.
- LW writing x5, followed by ADD reading x5 → stall=1 for exactly one cycle, one bubble (ex_valid=0), then the ADD bundle appears. Repeat with ex_rd=0 → no stall.
- Load-use hazard and redirect in the same cycle → stall=0, flush_ifid=1, bubble loaded.
- HALT with DRAIN_CYCLES=3 → stall=1 from the next cycle; halted=1 exactly 4 edges after the decode cycle; sticky for more than 10 cycles. HALT concurrent with redirect → no halt.
- Assert reset_n=0 mid-DRAIN → all outputs 0 at once; after release a normal ADD decodes correctly.
- AUIPC_EN=0 with Opcode 0010111 → all controls 0, ex_valid=1; unknown opcode 1010101 behaves the same.
